// File: rtl/counter_sequencer_if.sv
// Button, counter and status bundle between the sequencer and its environment.
interface counter_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start_btn;
  logic             stop_btn;
  logic             clear_btn;
  logic             lap_btn;
  logic [WIDTH-1:0] q;
  logic             cnt_en;
  logic             cnt_clr;
  logic [1:0]       state;
  logic             done;
  logic [WIDTH-1:0] lap_val;
  logic             lap_valid;

  modport master (
    output start_btn, stop_btn, clear_btn, lap_btn, q,
    input  cnt_en, cnt_clr, state, done, lap_val, lap_valid
  );

  modport slave (
    input  start_btn, stop_btn, clear_btn, lap_btn, q,
    output cnt_en, cnt_clr, state, done, lap_val, lap_valid
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run/pause/done sequencer driving an external counter through a prescaler,
// with synchronized button events and lap capture.
module counter_sequencer #(
  parameter int               WIDTH    = 16,
  parameter int               PRESCALE = 4,
  parameter logic [WIDTH-1:0] TERMINAL = WIDTH'(16'hFFFF)
) (
  input logic                clk,
  input logic                rst,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] r_prev;
  logic [3:0] r_armed;
  logic [1:0] r_boot;
  logic [3:0] w_ev;
  logic       w_start;
  logic       w_stop;
  logic       w_clear;
  logic       w_lap;

  assign w_raw = {bus.lap_btn, bus.clear_btn,
                  bus.stop_btn, bus.start_btn};

  // A button is armed only after it is seen low once the
  // synchronizer has filled, so levels held through reset stay silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_armed <= '0;
      r_boot  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_armed <= r_armed | ({4{r_boot == 2'd2}} & ~r_sync2);
      if (r_boot != 2'd2) r_boot <= r_boot + 2'd1;
    end
  end

  assign w_ev    = r_sync2 & ~r_prev & r_armed;
  assign w_start = w_ev[0];
  assign w_stop  = w_ev[1];
  assign w_clear = w_ev[2];
  assign w_lap   = w_ev[3];

  state_t          r_state;
  state_t          w_state_nx;
  logic [PW-1:0]   r_pre;
  logic [PW-1:0]   w_pre_nx;
  logic            w_term;
  logic            w_tick;
  logic            r_clr;
  logic [WIDTH-1:0] r_lap_val;
  logic            r_lap_valid;

  assign w_term = (bus.q == TERMINAL);
  assign w_tick = (r_state == S_RUN) && (r_pre == PRE_MAX);

  always_comb begin
    w_state_nx = r_state;
    w_pre_nx   = r_pre;
    if (r_state == S_RUN)
      w_pre_nx = w_tick ? '0 : r_pre + 1'b1;
    if (w_clear) begin
      w_state_nx = S_IDLE;
      w_pre_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_state_nx = S_RUN;
            w_pre_nx   = '0;
          end
        end
        S_RUN: begin
          if (w_stop)      w_state_nx = S_PAUSE;
          else if (w_term) w_state_nx = S_DONE;
        end
        S_PAUSE: begin
          if (w_start) w_state_nx = S_RUN;
        end
        S_DONE: w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_clr   <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_pre   <= w_pre_nx;
      r_clr   <= w_clear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_val   <= '0;
      r_lap_valid <= 1'b0;
    end else if (w_clear) begin
      r_lap_val   <= '0;
      r_lap_valid <= 1'b0;
    end else if (w_lap && r_state != S_IDLE) begin
      r_lap_val   <= bus.q;
      r_lap_valid <= 1'b1;
    end
  end

  assign bus.cnt_en    = w_tick && !w_term;
  assign bus.cnt_clr   = r_clr;
  assign bus.state     = r_state;
  assign bus.done      = (r_state == S_DONE);
  assign bus.lap_val   = r_lap_val;
  assign bus.lap_valid = r_lap_valid;

endmodule
